hist_eq_ctrl: RTL

//  Frame-level sequencer for the Hist_Eq datapath. Accumulates a 256-bin luminance

---
 rtl/hist_eq_pkg.sv | 25 ++
 rtl/hist_eq_ctrl_if.sv | 37 +++
 rtl/hist_eq_bins.sv | 53 +++++
 rtl/hist_eq_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/hist_eq_pkg.sv
// -----------------------------------------------------------------------------
// hist_eq_pkg
// Shared constants and the controller state type for the histogram-equalisation
// frame sequencer.
//   PIX_COUNT : pixels per 320x240 frame (must equal the constant inside Hist_Eq)
//   PIX_W     : pixel width; the histogram has 2**PIX_W bins
//   CNT_W     : bin / CDF / frame-counter width, 2**CNT_W > PIX_COUNT
//   NBINS     : number of histogram bins
// -----------------------------------------------------------------------------
package hist_eq_pkg;

    localparam int unsigned PIX_COUNT = 76800;
    localparam int unsigned PIX_W     = 8;
    localparam int unsigned CNT_W     = 17;
    localparam int unsigned NBINS     = 2 ** PIX_W;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        ACCUM,
        SCAN,
        MAP
    } state_t;

endpackage

// File: rtl/hist_eq_ctrl_if.sv
// -----------------------------------------------------------------------------
// hist_eq_ctrl_if
// Pixel stream handshakes around the frame sequencer.
//   in_valid / in_pixel / in_ready    : frame pixels from the decoded-frame buffer
//   out_valid / out_pixel / out_ready : remapped pixels to the filter output stage
// Modports:
//   master : the side that feeds pixels in and drains remapped pixels
//   slave  : the controller
// -----------------------------------------------------------------------------
interface hist_eq_ctrl_if;

    logic                          in_valid;
    logic [hist_eq_pkg::PIX_W-1:0] in_pixel;
    logic                          in_ready;
    logic                          out_valid;
    logic [hist_eq_pkg::PIX_W-1:0] out_pixel;
    logic                          out_ready;

    modport master (
        output in_valid,
        output in_pixel,
        input  in_ready,
        input  out_valid,
        input  out_pixel,
        output out_ready
    );

    modport slave (
        input  in_valid,
        input  in_pixel,
        output in_ready,
        output out_valid,
        output out_pixel,
        input  out_ready
    );

endinterface

// File: rtl/hist_eq_bins.sv
// -----------------------------------------------------------------------------
// hist_eq_bins
// Histogram storage: NBINS registers of CNT_W bits, combinational read,
// synchronous write. One shared address serves every operation.
//   clk   : clock
//   clear : bin[addr] <= 0
//   incr  : bin[addr] <= bin[addr] + 1 (read-modify-write in one cycle, so
//           back-to-back increments of the same bin are never lost)
//   wr    : bin[addr] <= wdata
//   addr  : bin index
//   wdata : write data for wr
//   rdata : bin[addr], combinational
// Priority when several strobes are high: clear, then incr, then wr.
// Bins carry no reset; the controller clears them at the start of every frame.
// -----------------------------------------------------------------------------
module hist_eq_bins
    import hist_eq_pkg::*;
(
    input  logic             clk,
    input  logic             clear,
    input  logic             incr,
    input  logic             wr,
    input  logic [PIX_W-1:0] addr,
    input  logic [CNT_W-1:0] wdata,
    output logic [CNT_W-1:0] rdata
);

    logic [CNT_W-1:0] bin_q [NBINS];

    for (genvar gi = 0; gi < NBINS; gi++) begin : g_bin
        logic [CNT_W-1:0] bin_reg;
        logic             hit;

        assign hit = (addr == PIX_W'(gi));

        always_ff @(posedge clk) begin
            if (hit) begin
                if (clear) begin
                    bin_reg <= '0;
                end else if (incr) begin
                    bin_reg <= bin_reg + CNT_W'(1);
                end else if (wr) begin
                    bin_reg <= wdata;
                end
            end
        end

        assign bin_q[gi] = bin_reg;
    end

    assign rdata = bin_q[addr];

endmodule

// File: rtl/hist_eq_ctrl.sv
// -----------------------------------------------------------------------------
// hist_eq_ctrl
// Frame-level sequencer for the Hist_Eq datapath. Builds a 256-bin luminance
// histogram over one frame, turns it in place into a CDF, finds cdf_min, then
// remaps a replay of the same frame through the external Hist_Eq block.
// FSM: IDLE -start-> CLEAR (256) -> ACCUM (FRAME_PIXELS accepts) -> SCAN (256)
//      -> MAP (FRAME_PIXELS output handshakes) -> IDLE with a one-cycle done.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   start     : begins a frame; ignored while busy
//   px        : pixel in/out streams (hist_eq_ctrl_if.slave)
//   cdf       : bin[in_pixel], to Hist_Eq.cdf
//   cdf_min   : first nonzero CDF value, to Hist_Eq.cdf_min
//   eq_pixel  : from Hist_Eq.pixel_out
//   bypass    : only when HIST_EQ_BYPASS_EN is defined; sampled at start, and
//               if set MAP passes in_pixel through unchanged
//   busy      : high whenever the FSM is not IDLE
//   done      : one-cycle pulse after the last output handshake
// Optional feature macro: HIST_EQ_BYPASS_EN
// -----------------------------------------------------------------------------
module hist_eq_ctrl
    import hist_eq_pkg::*;
#(
    parameter int unsigned FRAME_PIXELS = PIX_COUNT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    hist_eq_ctrl_if.slave    px,
    output logic [CNT_W-1:0] cdf,
    output logic [CNT_W-1:0] cdf_min,
    input  logic [PIX_W-1:0] eq_pixel,
`ifdef HIST_EQ_BYPASS_EN
    input  logic             bypass,
`endif
    output logic             busy,
    output logic             done
);

    localparam logic [CNT_W-1:0] LAST_PIX  = CNT_W'(FRAME_PIXELS - 1);
    localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_PIXELS);

    state_t           state_reg, state_next;
    logic [PIX_W-1:0] idx_reg;
    logic [CNT_W-1:0] in_cnt_reg;
    logic [CNT_W-1:0] out_cnt_reg;
    logic [CNT_W-1:0] sum_reg;
    logic [CNT_W-1:0] cdf_min_reg;
    logic             min_found_reg;
    logic             in_done_reg;
    logic             out_valid_reg;
    logic [PIX_W-1:0] out_pixel_reg;
    logic             done_reg;
    logic             bypass_reg;

    logic             bin_clear, bin_incr, bin_wr;
    logic [PIX_W-1:0] bin_addr;
    logic [CNT_W-1:0] bin_rdata;
    logic [CNT_W-1:0] sum_next;
    logic             in_ready;
    logic             in_accept, out_hs;
    logic             last_idx, last_in, last_out;
    logic             degenerate;
    logic             bypass_sel;
    logic [PIX_W-1:0] map_pixel;

`ifdef HIST_EQ_BYPASS_EN
    assign bypass_sel = bypass;
`else
    assign bypass_sel = 1'b0;
`endif

    hist_eq_bins u_bins (
        .clk   (clk),
        .clear (bin_clear),
        .incr  (bin_incr),
        .wr    (bin_wr),
        .addr  (bin_addr),
        .wdata (sum_next),
        .rdata (bin_rdata)
    );

    // CLEAR and SCAN walk the bins by index; ACCUM and MAP look up the
    // incoming pixel's bin.
    assign bin_addr  = (state_reg == CLEAR || state_reg == SCAN) ? idx_reg : px.in_pixel;
    assign sum_next  = sum_reg + bin_rdata;
    assign in_accept = px.in_valid & in_ready;
    assign out_hs    = out_valid_reg & px.out_ready;
    assign last_idx  = (idx_reg == PIX_W'(NBINS - 1));
    assign last_in   = (in_cnt_reg == LAST_PIX);
    assign last_out  = (out_cnt_reg == LAST_PIX);

    // A single-gray-level frame gives Hist_Eq a zero divisor; its output is
    // meaningless then, so the input pixel is passed straight through.
    assign degenerate = (cdf_min_reg == FRAME_CNT);
    assign map_pixel  = (bypass_reg | degenerate) ? px.in_pixel : eq_pixel;

    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        bin_clear  = 1'b0;
        bin_incr   = 1'b0;
        bin_wr     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) state_next = CLEAR;
            end
            CLEAR: begin
                bin_clear = 1'b1;
                if (last_idx) state_next = ACCUM;
            end
            ACCUM: begin
                in_ready = 1'b1;
                bin_incr = px.in_valid;
                if (px.in_valid && last_in) state_next = SCAN;
            end
            SCAN: begin
                bin_wr = 1'b1;
                if (last_idx) state_next = MAP;
            end
            MAP: begin
                // Single output register: accept when it is empty or draining,
                // and never past the end of the frame.
                in_ready = !in_done_reg && (px.out_ready || !out_valid_reg);
                if (out_hs && last_out) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            idx_reg       <= '0;
            in_cnt_reg    <= '0;
            out_cnt_reg   <= '0;
            sum_reg       <= '0;
            cdf_min_reg   <= '0;
            min_found_reg <= 1'b0;
            in_done_reg   <= 1'b0;
            out_valid_reg <= 1'b0;
            out_pixel_reg <= '0;
            done_reg      <= 1'b0;
            bypass_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            done_reg  <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        idx_reg       <= '0;
                        in_cnt_reg    <= '0;
                        out_cnt_reg   <= '0;
                        sum_reg       <= '0;
                        cdf_min_reg   <= '0;
                        min_found_reg <= 1'b0;
                        in_done_reg   <= 1'b0;
                        bypass_reg    <= bypass_sel;
                    end
                end
                CLEAR: begin
                    // Wraps 255 -> 0, leaving the index ready for SCAN.
                    idx_reg <= idx_reg + PIX_W'(1);
                end
                ACCUM: begin
                    if (in_accept) in_cnt_reg <= last_in ? '0 : in_cnt_reg + CNT_W'(1);
                end
                SCAN: begin
                    sum_reg <= sum_next;
                    idx_reg <= idx_reg + PIX_W'(1);
                    if (!min_found_reg && sum_next != '0) begin
                        cdf_min_reg   <= sum_next;
                        min_found_reg <= 1'b1;
                    end
                end
                MAP: begin
                    if (in_accept) begin
                        out_pixel_reg <= map_pixel;
                        out_valid_reg <= 1'b1;
                        if (last_in) in_done_reg <= 1'b1;
                        else         in_cnt_reg  <= in_cnt_reg + CNT_W'(1);
                    end else if (out_hs) begin
                        out_valid_reg <= 1'b0;
                    end
                    if (out_hs) begin
                        if (last_out) done_reg    <= 1'b1;
                        else          out_cnt_reg <= out_cnt_reg + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign px.in_ready  = in_ready;
    assign px.out_valid = out_valid_reg;
    assign px.out_pixel = out_pixel_reg;
    assign cdf          = bin_rdata;
    assign cdf_min      = cdf_min_reg;
    assign busy         = (state_reg != IDLE);
    assign done         = done_reg;

endmodule
